// File: rtl/injection_sweep_controller.sv
// Injection-rate sweep controller.
// Steps a traffic generator through NO_POINTS injection rates. Each point runs
// flush -> warm-up -> measure -> drain -> report. Packet count and latency sum
// are accumulated during measure and drain, and are handed out over a
// valid/ready report interface.
module injection_sweep_controller #(
   parameter int NO_POINTS     = 4,
   parameter int RATE_W        = 8,
   parameter int RATE_START    = 8,
   parameter int RATE_STEP     = 8,
   parameter int FLUSH_CYCLES  = 4,
   parameter int WARM_UP_TIME  = 2000,
   parameter int SIM_TIME      = 500000,
   parameter int DRAIN_TIMEOUT = 20000,
   parameter int CNT_W         = 32
) (
   input  logic              clk,
   input  logic              rs,
   input  logic              start,
   input  logic              busy,
   input  logic              pkt_rcv,
   input  logic [CNT_W-1:0]  lat_in,
   input  logic              report_ready,
   output logic              full_rs,
   output logic              inject_en,
   output logic [RATE_W-1:0] rate_code,
   output logic [2:0]        phase,
   output logic [7:0]        point_idx,
   output logic              report_valid,
   output logic [CNT_W-1:0]  report_pkts,
   output logic [CNT_W-1:0]  report_lat_sum,
   output logic [1:0]        report_flags,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FLUSH   = 3'd1,
      WARMUP  = 3'd2,
      MEASURE = 3'd3,
      DRAIN   = 3'd4,
      REPORT  = 3'd5,
      DONE    = 3'd6
   } state_t;

   // Each phase counter runs from 0 up to its "last" value, so a phase lasts
   // exactly N cycles.
   localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  WARM_LAST  = CNT_W'(WARM_UP_TIME - 1);
   localparam logic [CNT_W-1:0]  SIM_LAST   = CNT_W'(SIM_TIME - 1);
   localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [7:0]        LAST_PT    = 8'(NO_POINTS - 1);
   localparam logic [RATE_W-1:0] RATE_START_C = RATE_W'(RATE_START);
   localparam logic [RATE_W-1:0] RATE_STEP_C  = RATE_W'(RATE_STEP);

   // Widening adds. The top bit is the carry used for saturation.
   function automatic logic [CNT_W:0] add_cnt(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] s);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   function automatic logic [RATE_W-1:0] sat_rate_add(input logic [RATE_W-1:0] a,
                                                      input logic [RATE_W-1:0] b);
      logic [RATE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[RATE_W] ? '1 : s[RATE_W-1:0];
   endfunction

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                full_rs_q;
   logic                inject_q;
   logic [RATE_W-1:0]   rate_q;
   logic [7:0]          pt_q;
   logic                valid_q;
   logic [CNT_W-1:0]    pkts_q;
   logic [CNT_W-1:0]    lat_q;
   logic [1:0]          flags_q;
   logic                done_q;

   logic [CNT_W:0]      lat_ext;
   logic [CNT_W-1:0]    lat_d;
   logic [CNT_W-1:0]    pkts_d;
   logic [RATE_W-1:0]   rate_d;
   logic                count_en;

   // Saturating accumulate and rate-step values for the next edge.
   always_comb begin
      lat_ext  = add_cnt(lat_q, lat_in);
      lat_d    = sat_cnt(lat_ext);
      pkts_d   = sat_cnt(add_cnt(pkts_q, CNT_ONE));
      rate_d   = sat_rate_add(rate_q, RATE_STEP_C);
      count_en = pkt_rcv && ((state_q == MEASURE) || (state_q == DRAIN));
   end

   // Sweep FSM with registered outputs and statistics accumulation.
   always_ff @(posedge clk) begin
      if (rs) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         full_rs_q <= 1'b0;
         inject_q  <= 1'b0;
         rate_q    <= RATE_START_C;
         pt_q      <= '0;
         valid_q   <= 1'b0;
         pkts_q    <= '0;
         lat_q     <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         if (count_en) begin
            pkts_q <= pkts_d;
            lat_q  <= lat_d;
            if (lat_ext[CNT_W]) flags_q[0] <= 1'b1;
         end
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q   <= FLUSH;
                  cnt_q     <= '0;
                  pt_q      <= '0;
                  done_q    <= 1'b0;
                  rate_q    <= RATE_START_C;
                  full_rs_q <= 1'b1;
               end
            end
            FLUSH: begin
               // Statistics start clean for every point.
               pkts_q  <= '0;
               lat_q   <= '0;
               flags_q <= '0;
               if (cnt_q == FLUSH_LAST) begin
                  state_q   <= WARMUP;
                  cnt_q     <= '0;
                  full_rs_q <= 1'b0;
                  inject_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            WARMUP: begin
               if (cnt_q == WARM_LAST) begin
                  state_q <= MEASURE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            MEASURE: begin
               if (cnt_q == SIM_LAST) begin
                  state_q  <= DRAIN;
                  cnt_q    <= '0;
                  inject_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            DRAIN: begin
               // An idle network wins over a timeout landing on the same cycle.
               if (!busy) begin
                  state_q <= REPORT;
                  cnt_q   <= '0;
                  valid_q <= 1'b1;
               end else if (cnt_q == DRAIN_LAST) begin
                  state_q    <= REPORT;
                  cnt_q      <= '0;
                  valid_q    <= 1'b1;
                  flags_q[1] <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            REPORT: begin
               if (report_ready) begin
                  valid_q <= 1'b0;
                  if (flags_q[1] || (pt_q == LAST_PT)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= FLUSH;
                     cnt_q     <= '0;
                     pt_q      <= pt_q + 8'd1;
                     rate_q    <= rate_d;
                     full_rs_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign full_rs        = full_rs_q;
   assign inject_en      = inject_q;
   assign rate_code      = rate_q;
   assign phase          = state_q;
   assign point_idx      = pt_q;
   assign report_valid   = valid_q;
   assign report_pkts    = pkts_q;
   assign report_lat_sum = lat_q;
   assign report_flags   = flags_q;
   assign done           = done_q;

endmodule

// File: doc/injection_sweep_controller.md
INJECTION_SWEEP_CONTROLLER -- requirements
Module: injection_sweep_controller

Interface
REQ-001 Parameter NO_POINTS, default 4: number of injection-rate points in one sweep, range 1..255.
REQ-002 Parameter RATE_W, default 8: width of the rate code.
REQ-003 Parameter RATE_START, default 8: rate code of point 0.
REQ-004 Parameter RATE_STEP, default 8: rate-code increment per point; the sum saturates at 2^RATE_W-1.
REQ-005 Parameter FLUSH_CYCLES, default 4: number of cycles full_rs is held high per point, minimum 1.
REQ-006 Parameters WARM_UP_TIME, default 2000; SIM_TIME, default 500000; DRAIN_TIMEOUT, default 20000: phase lengths in cycles, each at least 1.
REQ-007 Parameter CNT_W, default 32: width of the statistics counters.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rs  in  1  synchronous active-high reset.
REQ-010 start  in  1  one-cycle request to begin a sweep.
REQ-011 busy  in  1  network has packets in flight.
REQ-012 pkt_rcv  in  1  one packet delivered this cycle.
REQ-013 lat_in  in  CNT_W  latency of the delivered packet, valid with pkt_rcv.
REQ-014 report_ready  in  1  report sink accepts.
REQ-015 full_rs  out  1  network/PE reset between points.
REQ-016 inject_en  out  1  PEs may inject.
REQ-017 rate_code  out  RATE_W  current injection-rate code.
REQ-018 phase  out  3  current FSM state encoding.
REQ-019 point_idx  out  8  index of the current point.
REQ-020 report_valid  out  1  report fields valid.
REQ-021 report_pkts, report_lat_sum  out  CNT_W each  packets counted and latency sum for the point.
REQ-022 report_flags  out  2  bit0 = latency-sum saturated; bit1 = drain timed out.
REQ-023 done  out  1  sweep finished; held high until the next start or rs.

Function
REQ-024 The FSM shall have the states IDLE=0, FLUSH=1, WARMUP=2, MEASURE=3, DRAIN=4, REPORT=5, DONE=6, encoded as shown on phase.
REQ-025 A start pulse in IDLE or DONE shall clear point_idx and done, load rate_code=RATE_START, and move the FSM to FLUSH on the next cycle; start in any other state shall be ignored.
REQ-026 FLUSH shall assert full_rs for exactly FLUSH_CYCLES cycles, clear the statistics counters and flags, and then enter WARMUP.
REQ-027 WARMUP shall last WARM_UP_TIME cycles with inject_en=1 and no counting, then enter MEASURE.
REQ-028 MEASURE shall last SIM_TIME cycles with inject_en=1, counting every pkt_rcv; it shall then enter DRAIN.
REQ-029 DRAIN shall hold inject_en=0 and keep counting pkt_rcv.
REQ-030 DRAIN shall exit to REPORT on the first cycle busy=0, or after DRAIN_TIMEOUT cycles with flag bit1 set.
REQ-031 In the DRAIN cycle where busy=0, a pkt_rcv pulse in that same cycle shall still be counted.
REQ-032 A pkt_rcv pulse in the last MEASURE cycle shall be counted.
REQ-033 Counting shall add 1 to report_pkts and add lat_in to report_lat_sum.
REQ-034 If an addition to report_lat_sum would overflow, report_lat_sum shall saturate at all-ones and flag bit0 shall be set.
REQ-035 report_pkts shall saturate at all-ones.
REQ-036 REPORT shall hold report_valid=1 with stable fields until report_ready=1; the transfer occurs on the cycle where both valid and ready are 1.
REQ-037 After the REPORT transfer, if flag bit1 is set or point_idx==NO_POINTS-1, the FSM shall enter DONE with done=1; otherwise it shall increment point_idx, add RATE_STEP to rate_code (saturating), and enter FLUSH.
REQ-038 Outputs in IDLE and DONE shall be full_rs=0, inject_en=0, report_valid=0; rate_code and point_idx shall retain their last values in DONE.
REQ-039 Phase cycle counters shall be CNT_W wide, and every phase length shall be exact, with no off-by-one.

Reset
REQ-040 When rs=1 at a rising edge, the block shall enter IDLE from any state.
REQ-041 The reset values shall be: all outputs 0, except rate_code=RATE_START; all counters and flags 0.
REQ-042 Reset shall take precedence over start and over report_ready in the same cycle.

Verification
REQ-043 Test 1: NO_POINTS=2, WARM_UP_TIME=10, SIM_TIME=20, FLUSH_CYCLES=4; start; busy drops 3 cycles into DRAIN; report_ready tied to 1. Required: full_rs high for 4 cycles; inject_en high for exactly 30 cycles per point; rate_code 8 then 16; done after the 2nd report.
REQ-044 Test 2: 5 pkt_rcv pulses with lat_in=100 in MEASURE, including one in the final MEASURE cycle, plus 1 pulse in DRAIN. Required: report_pkts=6, report_lat_sum=600, flags=0.
REQ-045 Test 3: busy held at 1 with DRAIN_TIMEOUT=50. Required: REPORT after exactly 50 DRAIN cycles; flags=2'b10; DONE after point 0 even though NO_POINTS=4.
REQ-046 Test 4: CNT_W=8, two pulses with lat_in=200. Required: report_lat_sum=255, flag bit0=1, report_pkts=2.
REQ-047 Test 5: report_ready held low for 7 cycles in REPORT. Required: report_valid=1 and fields stable throughout; no FLUSH until the handshake completes.
REQ-048 Test 6: rs asserted mid-MEASURE; start also pulsed mid-WARMUP. Required: rs → IDLE with all outputs at reset values on the next cycle; the mid-WARMUP start is ignored.
